fp_add_seq: RTL and testbench

- Multi-cycle IEEE-754 single-precision adder. It consumes two float_t operands and produces one float_t sum.
- Sits directly downstream of the floatingpointpkg types and classification helpers (IsZero/IsDenorm/IsNaN/IsInf). It is the arithmetic core that testbenches compare against $bitstoshortreal reference sums.
- Valid/ready handshake on both sides; one operation in flight at a time.
- Round-to-nearest-even; denormals flushed to zero (FTZ) on input and output.

---
 rtl/fp_add_seq_if.sv | 24 ++
 rtl/fp_add_seq.sv | 190 +++++++++++++++++++
 tb/tb_fp_add_seq.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/fp_add_seq_if.sv
// Operand/result handshake bundle for the sequential single-precision adder.
// master = producer/consumer side, slave = the adder itself.
interface fp_add_seq_if #(
   parameter int W = 32
);
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] result;
   logic [3:0]   flags;

   modport master (
      output in_valid, a, b, out_ready,
      input  in_ready, out_valid, result, flags
   );

   modport slave (
      input  in_valid, a, b, out_ready,
      output in_ready, out_valid, result, flags
   );
endinterface

// File: rtl/fp_add_seq.sv
// Multi-cycle IEEE-754 adder: IDLE->ALIGN->ADD->NORM->ROUND->DONE, RNE, FTZ in and out.
// flags = {invalid, overflow, underflow, inexact}.
module fp_add_seq #(
   parameter int EXPBITS  = 8,
   parameter int FRACBITS = 23
) (
   input logic        clk,
   input logic        reset,
   fp_add_seq_if.slave io
);
   localparam int W  = 1 + EXPBITS + FRACBITS;
   localparam int MW = FRACBITS + 4;            // hidden + fraction + G/R/S
   localparam int EB = EXPBITS + 2;             // signed exponent with headroom
   localparam int LW = $clog2(MW + 1);
   localparam logic [EXPBITS-1:0] EMAX = '1;
   localparam logic [EXPBITS-1:0] MWE  = EXPBITS'(MW);
   localparam logic [W-1:0] QNAN = {1'b0, EMAX, 1'b1, {(FRACBITS-1){1'b0}}};

   typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, ROUND, DONE} state_t;
   state_t state, state_n;

   logic [W-1:0]          ra, rb;
   logic                  sx, sub, spec, mz;
   logic signed [EB-1:0]  ex;
   logic [MW-1:0]         mx, my, m;
   logic [MW:0]           sum;
   logic [W-1:0]          spec_res, res_q;
   logic [3:0]            spec_flg, flg_q;

   function automatic logic [LW-1:0] lzc(input logic [MW-1:0] v);
      logic [LW-1:0] n;
      n = LW'(MW);
      for (int i = 0; i < MW; i++)
         if (v[i]) n = LW'(MW - 1 - i);
      return n;
   endfunction

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (io.in_valid) state_n = ALIGN;
         ALIGN:   state_n = ADD;
         ADD:     state_n = NORM;
         NORM:    state_n = ROUND;
         ROUND:   state_n = DONE;
         DONE:    if (io.out_ready) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   assign io.in_ready  = (state == IDLE);
   assign io.out_valid = (state == DONE);
   assign io.result    = res_q;
   assign io.flags     = flg_q;

   // ---- alignment / classification (combinational off latched operands)
   logic [EXPBITS-1:0]  e_a, e_b, x_e, y_e, d;
   logic [FRACBITS-1:0] f_a, f_b;
   logic                z_a, z_b, inf_a, inf_b, nan_a, nan_b, snan_a, snan_b, swap, x_s;
   logic [W-2:0]        mag_a, mag_b, x_mag, y_mag;
   logic [MW-1:0]       mx_al, my_raw, my_al;
   logic [2*MW-1:0]     my_sh;
   logic                al_spec;
   logic [W-1:0]        al_res;
   logic [3:0]          al_flg;

   always_comb begin
      {e_a, f_a} = ra[W-2:0];
      {e_b, f_b} = rb[W-2:0];
      z_a    = (e_a == '0);
      z_b    = (e_b == '0);
      inf_a  = (e_a == EMAX) && (f_a == '0);
      inf_b  = (e_b == EMAX) && (f_b == '0);
      nan_a  = (e_a == EMAX) && (f_a != '0);
      nan_b  = (e_b == EMAX) && (f_b != '0);
      snan_a = nan_a && !f_a[FRACBITS-1];
      snan_b = nan_b && !f_b[FRACBITS-1];
      // denormals collapse to zero magnitude before ordering
      mag_a  = z_a ? '0 : ra[W-2:0];
      mag_b  = z_b ? '0 : rb[W-2:0];
      swap   = (mag_b > mag_a);
      x_s    = swap ? rb[W-1] : ra[W-1];
      x_mag  = swap ? mag_b : mag_a;
      y_mag  = swap ? mag_a : mag_b;
      x_e    = x_mag[W-2:FRACBITS];
      y_e    = y_mag[W-2:FRACBITS];
      d      = x_e - y_e;
      mx_al  = (x_e == '0) ? '0 : {1'b1, x_mag[FRACBITS-1:0], 3'b000};
      my_raw = (y_e == '0) ? '0 : {1'b1, y_mag[FRACBITS-1:0], 3'b000};
      my_sh  = {my_raw, {MW{1'b0}}} >> d;
      if (d >= MWE) my_al = {{(MW-1){1'b0}}, |my_raw};
      else          my_al = {my_sh[2*MW-1:MW+1], my_sh[MW] | (|my_sh[MW-1:0])};

      al_spec = 1'b0;
      al_res  = QNAN;
      al_flg  = 4'h0;
      if (nan_a || nan_b) begin
         al_spec = 1'b1;
         al_flg  = {snan_a | snan_b, 3'b000};
      end else if (inf_a && inf_b && (ra[W-1] != rb[W-1])) begin
         al_spec = 1'b1;
         al_flg  = 4'b1000;
      end else if (inf_a) begin
         al_spec = 1'b1;
         al_res  = ra;
      end else if (inf_b) begin
         al_spec = 1'b1;
         al_res  = rb;
      end else if (z_a && z_b) begin
         al_spec = 1'b1;
         al_res  = {ra[W-1] & rb[W-1], {(W-1){1'b0}}};
      end
   end

   // ---- rounding (combinational off normalised mantissa)
   logic [LW-1:0]         lz;
   logic                  inc, ovf, unf;
   logic [FRACBITS+1:0]   mr;
   logic signed [EB-1:0]  er;
   logic [FRACBITS-1:0]   fr;

   always_comb begin
      lz  = lzc(sum[MW-1:0]);
      inc = m[2] & (m[1] | m[0] | m[3]);
      mr  = {1'b0, m[MW-1:3]} + {{(FRACBITS+1){1'b0}}, inc};
      er  = ex + $signed({{(EB-1){1'b0}}, mr[FRACBITS+1]});
      fr  = mr[FRACBITS+1] ? mr[FRACBITS:1] : mr[FRACBITS-1:0];
      ovf = !er[EB-1] && (er >= $signed({2'b00, EMAX}));
      unf = er[EB-1] || (er == '0);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         res_q <= '0;
         flg_q <= '0;
      end else begin
         case (state)
            IDLE: if (io.in_valid) begin
               ra <= io.a;
               rb <= io.b;
            end
            ALIGN: begin
               sx       <= x_s;
               sub      <= ra[W-1] ^ rb[W-1];
               ex       <= $signed({2'b00, x_e});
               mx       <= mx_al;
               my       <= my_al;
               spec     <= al_spec;
               spec_res <= al_res;
               spec_flg <= al_flg;
            end
            ADD: sum <= sub ? {1'b0, mx} - {1'b0, my} : {1'b0, mx} + {1'b0, my};
            NORM: begin
               mz <= (sum == '0);
               if (sum[MW]) begin
                  m  <= {sum[MW:2], sum[1] | sum[0]};
                  ex <= ex + EB'(1);
               end else begin
                  m  <= sum[MW-1:0] << lz;
                  ex <= ex - $signed({{(EB-LW){1'b0}}, lz});
               end
            end
            ROUND: begin
               if (spec) begin
                  res_q <= spec_res;
                  flg_q <= spec_flg;
               end else if (mz) begin
                  res_q <= '0;
                  flg_q <= 4'h0;
               end else if (ovf) begin
                  res_q <= {sx, EMAX, {FRACBITS{1'b0}}};
                  flg_q <= 4'b0101;
               end else if (unf) begin
                  res_q <= {sx, {(W-1){1'b0}}};
                  flg_q <= 4'b0011;
               end else begin
                  res_q <= {sx, er[EXPBITS-1:0], fr};
                  flg_q <= {3'b000, m[2] | m[1] | m[0]};
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_fp_add_seq.sv
// Directed bench for fp_add_seq: literal vectors plus a real-arithmetic reference model
// checked on every cycle the result is presented.
module tb_fp_add_seq;
   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   fp_add_seq_if #(.W(32)) bus();

   fp_add_seq #(.EXPBITS(8), .FRACBITS(23)) dut (
      .clk(clk),
      .reset(reset),
      .io(bus)
   );

   int tests = 0;
   int fails = 0;
   int xfers = 0;
   logic [35:0] exp_q[$];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      tests++;
      if (got !== want) begin
         fails++;
         $display("FAIL %s: got %h want %h", name, got, want);
      end
   endtask

   // float bits -> real, denormals flushed to signed zero
   function automatic real f2r(input logic [31:0] x);
      logic [63:0] d;
      if (x[30:23] == 8'h00) d = {x[31], 63'b0};
      else                   d = {x[31], 11'(x[30:23]) + 11'd896, x[22:0], 29'b0};
      return $bitstoreal(d);
   endfunction

   // {flags, result}: exact sum via double + TwoSum residue, then RNE to 24 bits with FTZ
   function automatic logic [35:0] model(input logic [31:0] a, input logic [31:0] b);
      logic an, bn, as, bs, ai, bi, g, st, inx;
      real  x, y, s, bb, err;
      logic [63:0] sb;
      logic [23:0] fr;
      int   e;
      an = (a[30:23] == 8'hFF) && (a[22:0] != 0);
      bn = (b[30:23] == 8'hFF) && (b[22:0] != 0);
      as = an && !a[22];
      bs = bn && !b[22];
      ai = (a[30:23] == 8'hFF) && (a[22:0] == 0);
      bi = (b[30:23] == 8'hFF) && (b[22:0] == 0);
      if (an || bn) return {as | bs, 3'b000, 32'h7FC00000};
      if (ai && bi && (a[31] != b[31])) return {4'b1000, 32'h7FC00000};
      if (ai) return {4'b0000, a};
      if (bi) return {4'b0000, b};
      x   = f2r(a);
      y   = f2r(b);
      s   = x + y;
      bb  = s - x;
      err = (x - (s - bb)) + (y - bb);
      sb  = $realtobits(s);
      if (s == 0.0) return {4'b0000, sb[63], 31'b0};
      e   = int'(sb[62:52]) - 1023 + 127;
      g   = sb[28];
      st  = (|sb[27:0]) || (err != 0.0);
      inx = g | st;
      fr  = {1'b0, sb[51:29]};
      if (g && (st || sb[29])) fr = fr + 24'd1;
      if (fr[23]) e = e + 1;
      if (e >= 255) return {4'b0101, sb[63], 8'hFF, 23'b0};
      if (e <= 0)   return {4'b0011, sb[63], 31'b0};
      return {3'b000, inx, sb[63], e[7:0], fr[22:0]};
   endfunction

   // scoreboard: model value pushed on accept, checked every cycle out_valid is high
   always @(negedge clk) begin
      if (reset) exp_q.delete();
      else begin
         if (bus.out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL spurious_out_valid: got result %h with no op pending", bus.result);
            end else begin
               chk("model_result", bus.result, exp_q[0][31:0]);
               chk("model_flags", 32'(bus.flags), 32'(exp_q[0][35:32]));
               if (bus.out_ready) begin
                  void'(exp_q.pop_front());
                  xfers++;
               end
            end
         end
         if (bus.in_valid && bus.in_ready) exp_q.push_back(model(bus.a, bus.b));
      end
   end

   task automatic do_op(input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] want_r, input logic [3:0] want_f,
                        input string name);
      int n;
      logic [35:0] mv;
      @(posedge clk); #1;
      bus.in_valid = 1'b1;
      bus.a = x;
      bus.b = y;
      n = 0;
      while (bus.in_ready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
      if (n >= 50) begin
         tests++; fails++;
         $display("FAIL %s_accept: got no in_ready within %0d cycles", name, n);
         bus.in_valid = 1'b0;
         return;
      end
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      n = 0;
      while (bus.out_valid !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
      chk({name, "_latency"}, 32'(n), 32'd4);
      chk({name, "_result"}, bus.result, want_r);
      chk({name, "_flags"}, 32'(bus.flags), 32'(want_f));
      mv = model(x, y);
      chk({name, "_model_pin"}, mv[31:0], want_r);
      chk({name, "_model_pin_flags"}, 32'(mv[35:32]), 32'(want_f));
      if (bus.out_ready) begin
         @(posedge clk); #1;
         chk({name, "_out_valid_drop"}, 32'(bus.out_valid), 32'd0);
         chk({name, "_in_ready_back"}, 32'(bus.in_ready), 32'd1);
      end
   endtask

   localparam int NV = 18;
   logic [31:0] va [NV] = '{32'h3F800000, 32'h3F800000, 32'h80000000, 32'h00000001,
                            32'h7F7FFFFF, 32'h7F800000, 32'h7FC00000, 32'h3F800000,
                            32'h3F800001, 32'h3F800000, 32'h7F800001, 32'h00800001,
                            32'h7F800000, 32'h40400000, 32'h3FC00000, 32'h4B800000,
                            32'h4B800001, 32'hC0000000};
   logic [31:0] vb [NV] = '{32'h40000000, 32'hBF800000, 32'h80000000, 32'h00000000,
                            32'h7F7FFFFF, 32'hFF800000, 32'h3F800000, 32'h33800000,
                            32'h33800000, 32'h00800000, 32'h3F800000, 32'h80800000,
                            32'h3F800000, 32'hC0000000, 32'h3FC00000, 32'h3F800000,
                            32'h3F800000, 32'h3F800000};
   logic [31:0] vr [NV] = '{32'h40400000, 32'h00000000, 32'h80000000, 32'h00000000,
                            32'h7F800000, 32'h7FC00000, 32'h7FC00000, 32'h3F800000,
                            32'h3F800002, 32'h3F800000, 32'h7FC00000, 32'h00000000,
                            32'h7F800000, 32'h3F800000, 32'h40400000, 32'h4B800000,
                            32'h4B800002, 32'hBF800000};
   logic [3:0]  vf [NV] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000,
                            4'b0101, 4'b1000, 4'b0000, 4'b0001,
                            4'b0001, 4'b0001, 4'b1000, 4'b0011,
                            4'b0000, 4'b0000, 4'b0000, 4'b0001,
                            4'b0001, 4'b0000};

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int x0;
      bus.in_valid  = 1'b0;
      bus.a         = '0;
      bus.b         = '0;
      bus.out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      chk("reset_in_ready", 32'(bus.in_ready), 32'd1);
      chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
      chk("reset_result", bus.result, 32'h0);
      chk("reset_flags", 32'(bus.flags), 32'h0);

      for (int i = 0; i < NV; i++) do_op(va[i], vb[i], vr[i], vf[i], $sformatf("vec%0d", i));

      // backpressure: hold DONE for 3 cycles with a competing request
      bus.out_ready = 1'b0;
      do_op(32'h40400000, 32'hC0000000, 32'h3F800000, 4'b0000, "bp");
      x0 = xfers;
      bus.in_valid = 1'b1;
      bus.a = 32'h40000000;
      bus.b = 32'h40000000;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         chk("bp_result_hold", bus.result, 32'h3F800000);
         chk("bp_flags_hold", 32'(bus.flags), 32'h0);
         chk("bp_out_valid_hold", 32'(bus.out_valid), 32'd1);
         chk("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp_release_out_valid", 32'(bus.out_valid), 32'd0);
      chk("bp_one_transfer", 32'(xfers), 32'(x0 + 1));
      repeat (3) @(posedge clk);
      #1;
      chk("bp_no_extra_transfer", 32'(xfers), 32'(x0 + 1));
      chk("bp_idle_out_valid", 32'(bus.out_valid), 32'd0);

      // reset while the op sits in ADD
      @(posedge clk); #1;
      bus.in_valid = 1'b1;
      bus.a = 32'h3F800000;
      bus.b = 32'h40000000;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      chk("rst_mid_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_mid_in_ready", 32'(bus.in_ready), 32'd1);
      chk("rst_mid_result", bus.result, 32'h0);
      chk("rst_mid_flags", 32'(bus.flags), 32'h0);
      repeat (6) @(posedge clk);
      #1;
      chk("rst_mid_discarded", 32'(bus.out_valid), 32'd0);
      do_op(32'h3F800000, 32'h3F800000, 32'h40000000, 4'b0000, "after_rst");

      repeat (3) @(posedge clk);
      #1;
      chk("scoreboard_drain", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
